// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - display register write port and scanned pin outputs of seg_scan_driver
interface seg_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp;
  logic [DIGITS-1:0]     digit_en;
  logic [DIGITS-1:0]     sel_out;
  logic [7:0]            seg_out;
  logic                  frame_done;
  logic                  updated;

  modport master (
    output load, value, dp, digit_en,
    input  sel_out, seg_out, frame_done, updated
  );

  modport slave (
    input  load, value, dp, digit_en,
    output sel_out, seg_out, frame_done, updated
  );
endinterface

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - double-buffered multiplexed 7-segment scan driver, active-low pins
// Optional leading-zero suppression: define SEG_LZ_BLANK_EN.
module seg_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_scan_driver_if.slave bus
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [DW-1:0]         div_cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   act_value, pend_value;
  logic [DIGITS-1:0]     act_dp, pend_dp;
  logic [DIGITS-1:0]     act_en, pend_en;
  logic                  pend_valid;
  logic                  tick_q, commit_q;
  logic                  frame_done_q, updated_q;
  logic [DIGITS-1:0]     sel_q, sel_nxt, sel_hot;
  logic [7:0]            seg_q, seg_nxt;
  logic [DIGITS-1:0]     lz_blank;
  logic [3:0]            nib;
  logic                  cur_dp, cur_en, cur_lz;
  logic                  slot_wrap, frame_tick, commit;

  assign slot_wrap  = (div_cnt == DIV_LAST);
  assign frame_tick = slot_wrap && (idx == IDX_LAST);
  assign commit     = frame_tick && pend_valid;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

`ifdef SEG_LZ_BLANK_EN
  logic upper_zero;

  // Walk down from the most significant digit; a lit dp keeps its digit visible.
  always_comb begin
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero  = upper_zero & (act_value[4*i +: 4] == 4'h0);
      lz_blank[i] = upper_zero & ~act_dp[i];
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    nib     = 4'h0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    cur_lz  = 1'b0;
    sel_hot = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib        = act_value[4*i +: 4];
        cur_dp     = act_dp[i];
        cur_en     = act_en[i];
        cur_lz     = lz_blank[i];
        sel_hot[i] = 1'b0;
      end
    end
    if ((int'(div_cnt) < BLANK_CYCLES) || !cur_en || cur_lz) begin
      sel_nxt = '1;
      seg_nxt = 8'hFF;
    end else begin
      sel_nxt = sel_hot;
      seg_nxt = {~cur_dp, hex7(nib)};
    end
  end

  // frame_done/updated go through two stages so they land with digit 0's first pin cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      idx          <= '0;
      act_value    <= '0;
      act_dp       <= '0;
      act_en       <= '0;
      pend_value   <= '0;
      pend_dp      <= '0;
      pend_en      <= '0;
      pend_valid   <= 1'b0;
      tick_q       <= 1'b0;
      commit_q     <= 1'b0;
      frame_done_q <= 1'b0;
      updated_q    <= 1'b0;
      sel_q        <= '1;
      seg_q        <= 8'hFF;
    end else begin
      div_cnt <= slot_wrap ? '0 : div_cnt + DW'(1);
      if (slot_wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
      if (commit) begin
        act_value <= pend_value;
        act_dp    <= pend_dp;
        act_en    <= pend_en;
      end
      if (bus.load) begin
        pend_value <= bus.value;
        pend_dp    <= bus.dp;
        pend_en    <= bus.digit_en;
        pend_valid <= 1'b1;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end
      tick_q       <= frame_tick;
      commit_q     <= commit;
      frame_done_q <= tick_q;
      updated_q    <= commit_q;
      sel_q        <= sel_nxt;
      seg_q        <= seg_nxt;
    end
  end

  assign bus.sel_out    = sel_q;
  assign bus.seg_out    = seg_q;
  assign bus.frame_done = frame_done_q;
  assign bus.updated    = updated_q;

endmodule
